// File: rtl/macguffin_pkg.sv
// macguffin_pkg: shared widths, cipher constants and the tag/arbiter types
// Items:
//   BLOCK_W      cipher block width carried on every AXI-Stream port
//   ROUND_KEY_W  round-key width used by the attached encryption core
//   ROUNDS       round count of the attached encryption core
//   src_id_t     requester identity carried through the tag FIFO
//   arb_state_t  arbiter FSM states
package macguffin_pkg;
  localparam int BLOCK_W = 64;
  localparam int ROUND_KEY_W = 48;
  localparam int ROUNDS = 32;
  typedef enum logic {SRC0 = 1'b0, SRC1 = 1'b1} src_id_t;
  typedef enum logic [1:0] {ARB = 2'd0, HOLD0 = 2'd1, HOLD1 = 2'd2} arb_state_t;
  function automatic src_id_t other_src(input src_id_t s);
    return s == SRC0 ? SRC1 : SRC0;
  endfunction
endpackage

// File: rtl/macguffin_arbiter_tag_fifo.sv
// tag_fifo: synchronous FIFO of requester IDs, one entry per block inside the cipher
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   push, din         write request and source ID (ignored when full)
//   pop               read request (ignored when empty)
//   dout              source ID at the head
//   full, empty       occupancy flags
//   count             current occupancy, 0..DEPTH
module tag_fifo
  import macguffin_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  src_id_t                din,
  input  logic                   pop,
  output src_id_t                dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  src_id_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  // full/empty are evaluated before this cycle's opposite operation: no bypass
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem_q[rd_q];
  assign count = cnt_q;
  assign cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end
  // DEPTH is a power of two, so the pointers wrap by plain overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(do_push);
      rd_q <= rd_q + AW'(do_pop);
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/macguffin_arbiter.sv
// macguffin_arbiter: round-robin 2:1 arbiter in front of a block cipher, with tag-based return routing
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   s0_axis_*, s1_axis_*          plaintext streams from requesters 0/1
//   m0_axis_*, m1_axis_*          ciphertext streams back to requesters 0/1
//   enc_s_axis_*                  plaintext into the encryption core
//   enc_m_axis_*                  ciphertext out of the encryption core
//   inflight                      blocks accepted by the core and not yet delivered
//   err                           sticky: core produced output with no block outstanding
module macguffin_arbiter
  import macguffin_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [BLOCK_W-1:0]     s0_axis_tdata,
  input  logic                   s0_axis_tvalid,
  output logic                   s0_axis_tready,
  input  logic [BLOCK_W-1:0]     s1_axis_tdata,
  input  logic                   s1_axis_tvalid,
  output logic                   s1_axis_tready,
  output logic [BLOCK_W-1:0]     m0_axis_tdata,
  output logic                   m0_axis_tvalid,
  input  logic                   m0_axis_tready,
  output logic [BLOCK_W-1:0]     m1_axis_tdata,
  output logic                   m1_axis_tvalid,
  input  logic                   m1_axis_tready,
  output logic [BLOCK_W-1:0]     enc_s_axis_tdata,
  output logic                   enc_s_axis_tvalid,
  input  logic                   enc_s_axis_tready,
  input  logic [BLOCK_W-1:0]     enc_m_axis_tdata,
  input  logic                   enc_m_axis_tvalid,
  output logic                   enc_m_axis_tready,
  output logic [$clog2(DEPTH):0] inflight,
  output logic                   err
);
  arb_state_t state_q, state_d;
  src_id_t last_q, last_d, grant, head;
  logic gnt_valid, push, tag_full, tag_empty, err_q, err_d;
  // HOLD states pin the grant until the stalled requester completes its transfer
  always_comb begin
    grant = state_q == HOLD0 ? SRC0 :
            state_q == HOLD1 ? SRC1 :
            (s0_axis_tvalid && s1_axis_tvalid) ? other_src(last_q) :
            s1_axis_tvalid ? SRC1 : SRC0;
    // every handshake-capable output is gated by rst so nothing is offered while in reset
    gnt_valid = rst && (grant == SRC1 ? s1_axis_tvalid : s0_axis_tvalid);
    enc_s_axis_tvalid = gnt_valid && !tag_full;
    enc_s_axis_tdata = grant == SRC1 ? s1_axis_tdata : s0_axis_tdata;
    push = enc_s_axis_tvalid && enc_s_axis_tready;
    s0_axis_tready = rst && grant == SRC0 && enc_s_axis_tready && !tag_full;
    s1_axis_tready = rst && grant == SRC1 && enc_s_axis_tready && !tag_full;
    // the head tag steers each ciphertext block back to its requester, preserving order
    m0_axis_tvalid = rst && enc_m_axis_tvalid && !tag_empty && head == SRC0;
    m1_axis_tvalid = rst && enc_m_axis_tvalid && !tag_empty && head == SRC1;
    m0_axis_tdata = enc_m_axis_tdata;
    m1_axis_tdata = enc_m_axis_tdata;
    enc_m_axis_tready = rst && !tag_empty && (head == SRC1 ? m1_axis_tready : m0_axis_tready);
    state_d = push ? ARB : gnt_valid ? (grant == SRC1 ? HOLD1 : HOLD0) : state_q;
    last_d = push ? grant : last_q;
    err_d = err_q || (enc_m_axis_tvalid && tag_empty);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB;
      last_q <= SRC1;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
  tag_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (grant),
    .pop   (enc_m_axis_tvalid && enc_m_axis_tready),
    .dout  (head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (inflight)
  );
endmodule

// File: doc/macguffin_arbiter.md
MACGUFFIN_ARBITER -- requirements
Module: macguffin_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 32, meaning maximum blocks in flight inside the encryption pipeline (tag FIFO depth, power of two).
REQ-002 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports s0_axis_tdata/tvalid/tready  in/in/out  64/1/1  requester 0 plaintext stream.
REQ-005 SHALL have ports s1_axis_tdata/tvalid/tready  in/in/out  64/1/1  requester 1 plaintext stream.
REQ-006 SHALL have ports m0_axis_tdata/tvalid/tready  out/out/in  64/1/1  ciphertext to requester 0.
REQ-007 SHALL have ports m1_axis_tdata/tvalid/tready  out/out/in  64/1/1  ciphertext to requester 1.
REQ-008 SHALL have ports enc_s_axis_tdata/tvalid/tready  out/out/in  64/1/1  to encryption slave.
REQ-009 SHALL have ports enc_m_axis_tdata/tvalid/tready  in/in/out  64/1/1  from encryption master.
REQ-010 SHALL have port inflight  output  $clog2(DEPTH)+1  blocks accepted by encryption, not yet delivered.
REQ-011 SHALL have port err  output  1  sticky protocol-error flag.

Function
REQ-012 Arbiter FSM SHALL have states ARB, HOLD0, HOLD1; reset state ARB.
REQ-013 In ARB, grant SHALL be round-robin: both valid -> requester not last served; one valid -> that one.
REQ-014 Granted requester with tvalid=1 but no handshake SHALL move FSM to HOLD<i>; grant frozen until that handshake.
REQ-015 HOLD<i> SHALL return to ARB on the cycle of requester i's handshake; last-served updates only on handshakes.
REQ-016 enc_s_axis_tvalid SHALL equal granted sN_axis_tvalid AND NOT tag_full; tdata SHALL be granted sN_axis_tdata.
REQ-017 sN_axis_tready SHALL be 1 only when N granted AND enc_s_axis_tready AND NOT tag_full; non-granted tready SHALL be 0.
REQ-018 Each enc_s handshake SHALL push granted source ID (0/1) into tag FIFO, same cycle.
REQ-019 Head tag SHALL route output: mH_axis_tvalid = enc_m_axis_tvalid AND NOT tag_empty; other m tvalid 0; both m tdata = enc_m_axis_tdata.
REQ-020 enc_m_axis_tready SHALL equal mH_axis_tready AND NOT tag_empty; each enc_m handshake pops one tag.
REQ-021 Push and pop in same cycle SHALL both occur; inflight unchanged; push still blocked when full before the pop (no bypass).
REQ-022 Full (inflight=DEPTH) SHALL deassert both sN tready; empty SHALL hold enc_m_axis_tready at 0.
REQ-023 enc_m_axis_tvalid=1 while tag FIFO empty SHALL set err on next edge; err clears only on reset.
REQ-024 Arbiter SHALL add zero latency: combinational path sN -> enc_s and enc_m -> mN; inflight, FSM, tags registered.
REQ-025 Back-pressure on one destination SHALL stall all output (in-order delivery); no reordering.

Reset
REQ-026 rst low SHALL asynchronously force FSM=ARB, last-served=1 (requester 0 wins first tie), FIFO empty, inflight=0, err=0.
REQ-027 During reset all tvalid and tready outputs SHALL be 0.
REQ-028 Reset mid-operation SHALL discard all tags; encryption block is reset by the same rst.

Structure
REQ-029 Package macguffin_pkg SHALL hold BLOCK_W=64, ROUND_KEY_W=48, ROUNDS=32, src_id_t (1-bit enum SRC0/SRC1).
REQ-030 One sub-module tag_fifo (synchronous FIFO of src_id_t, DEPTH entries, full/empty/count) SHALL be instantiated once.

Verification
REQ-031 Only s0 sends 0x0000000100000000, encryptor always ready -> result on m0 only, m1_axis_tvalid never 1, inflight returns to 0.
REQ-032 s0 and s1 valid every cycle, 8 blocks each -> enc input alternates 0,1,0,1 starting with s0; 8 results on each m in order.
REQ-033 enc_s_axis_tready=0 for 5 cycles with s0 valid, s1 raising valid at cycle 2 -> grant stays s0 (HOLD0), s0 transfers first, then s1.
REQ-034 m0_axis_tready=0, 40 blocks offered from s1 then s0 -> inflight saturates at 32, sN tready 0 at full; on release all delivered in order.
REQ-035 Drive enc_m_axis_tvalid=1 with FIFO empty -> err=1 next cycle, stays 1 until rst low.
REQ-036 rst low mid-stream with inflight=10 -> all tvalid/tready 0 immediately, inflight=0, err=0; traffic after release correct.
